reorder_buffer: RTL and testbench
=================================

// Module: reorder_buffer
// PURPOSE
//  In-order completion tracker for the out-of-order core, and the producer of the commit interface.
//  Allocates one ROB entry per dispatched instruction and returns its id to rename/inst_queue.
//  Marks entries done from the writeback bus and retires them in program order.
//  Retirement is driven on commit_e_/commit_rd/commit_rob_id, at most one per cycle.
// PARAMETERS
//  ROB_DEPTH  `RobDepth  entry count; must be a power of 2 (>=4)
//  ROB        $clog2(ROB_DEPTH)  rob id width (derived)
// PORTS
//  clk            in   1          clock; all state updates on posedge
//  reset          in   1          synchronous, active-high reset
//  flush_         in   1          synchronous flush, active-low
//  dec_e_         in   1          allocate request, active-low
//  dec_rd         in   RegFile_t  architectural destination of allocating inst
//  dec_rob_id     out  ROB        id granted to the current allocation (= tail)
//  busy           out  1          ROB full; dispatch must hold dec_e_ = Disable_
//  wb_e_          in   1          writeback valid, active-low
//  wb_rd          in   RegFile_t  writeback tag; addr = rob id when regtype==TYPE_ROB
//  wb_exp         in   1          completing instruction raised an exception
//  commit_e_      out  1          commit valid, active-low, registered
//  commit_rd      out  RegFile_t  architectural rd of committing entry, registered
//  commit_rob_id  out  ROB        id of committing entry, registered
//  commit_exp     out  1          committing entry carries exception, registered
// BEHAVIOUR
//  - State: per entry {valid, done, exp, rd}. head/tail pointers ROB bits wide; count 0..ROB_DEPTH.
//  - Priority per edge: reset > flush_ > normal operation.
//  - Reset and flush: all valid=0, head=tail=count=0.
//    Outputs: commit_e_=Disable_, commit_rd=0, commit_rob_id=0, commit_exp=0, busy=0, dec_rob_id=0.
//  - Outputs after flush take effect from the next cycle; wb and alloc in the flush cycle are dropped.
//  - dec_rob_id = tail, combinational.
//  - busy = (count==ROB_DEPTH), from registered count.
//  - Allocate: dec_e_==Enable_ && !busy -> entry[tail] = {1,0,0,dec_rd}; tail = tail+1 mod ROB_DEPTH.
//  - dec_e_ while busy: ignored; no state change, even if a commit happens in the same cycle.
//  - Writeback: wb_e_==Enable_ && wb_rd.regtype==TYPE_ROB && entry[wb_rd.addr].valid
//    -> done=1, exp=wb_exp.
//    wb to an invalid entry, or with a non-ROB regtype: ignored.
//  - Commit: entry[head].valid && entry[head].done at the start of the cycle.
//    At that edge: register commit_e_=Enable_, commit_rd, commit_rob_id=head, commit_exp.
//    Same edge: clear entry[head].valid; head = head+1 mod ROB_DEPTH.
//    Otherwise commit_e_=Disable_; commit_rd/rob_id/exp hold their last values.
//  - Latency: wb_e_ in cycle t -> commit_e_ low in cycle t+2 (done bit is registered, then commit is registered).
//  - Throughput: back-to-back commits, one per cycle, while the head is done.
//  - Alloc and commit in the same cycle: count unchanged. Alloc only: +1. Commit only: -1.
//  - Commits in order only: done entries behind an undone head wait.
//  - Wrap-around: pointers roll ROB_DEPTH-1 -> 0 with no gap. Full vs empty is resolved by count, not pointer compare.
//  - Exception: commit_exp is informational only. The ROB does not self-flush; upstream asserts flush_.
// TESTING (ROB_DEPTH=8)
//  1. reset, alloc rd GPR5,6,7 on 3 cycles -> dec_rob_id 0,1,2; busy=0; commit_e_ stays Disable_.
//  2. wb ROB1, then next cycle wb ROB0
//     -> commit rob_id 0 (rd GPR5), then rob_id 1 (rd GPR6) on consecutive cycles.
//     rob 2 not committed.
//  3. 8 allocs with no wb -> busy=1 after the 8th.
//     9th dec_e_ ignored (dec_rob_id unchanged).
//     wb head -> commit; busy=0 the cycle after the commit edge.
//  4. 10 alloc/wb/commit sequences -> commit_rob_id runs 0..7,0,1. Next dec_rob_id=2; no lost or duplicated commits.
//  5. 4 pending (2 done, not yet committed), flush_ asserted
//     -> no commit_e_ after flush; dec_rob_id=0, busy=0; later wb ROB0 is ignored.
//  6. wb ROB0 with wb_exp=1, wb ROB1 with wb_exp=0
//     -> commit ROB0 with commit_exp=1, then ROB1 with commit_exp=0.
//  7. wb_rd regtype TYPE_GPR addr 0 with ROB0 pending -> no done set; no commit.

Source files
------------

// File: rtl/reorder_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module   : reorder_buffer_if
//  Purpose  : Dispatch / writeback / commit signal bundle of the reorder buffer.
//             The master side is the core front end; the slave side is the ROB.
//             Register tags are {regtype[1:0], addr[4:0]}.
//  Revision : 1.0 - initial release
// ============================================================================
interface reorder_buffer_if #(
  parameter int ROB_DEPTH = 8,
  parameter int REG_W     = 7
);
  localparam int ROB = $clog2(ROB_DEPTH);

  logic             flush_;
  logic             dec_e_;
  logic [REG_W-1:0] dec_rd;
  logic [ROB-1:0]   dec_rob_id;
  logic             busy;
  logic             wb_e_;
  logic [REG_W-1:0] wb_rd;
  logic             wb_exp;
  logic             commit_e_;
  logic [REG_W-1:0] commit_rd;
  logic [ROB-1:0]   commit_rob_id;
  logic             commit_exp;

  modport master (
    output flush_, dec_e_, dec_rd, wb_e_, wb_rd, wb_exp,
    input  dec_rob_id, busy, commit_e_, commit_rd, commit_rob_id, commit_exp
  );

  modport slave (
    input  flush_, dec_e_, dec_rd, wb_e_, wb_rd, wb_exp,
    output dec_rob_id, busy, commit_e_, commit_rd, commit_rob_id, commit_exp
  );
endinterface
`default_nettype wire

// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : reorder_buffer
//  Purpose  : In-order completion tracker. Allocates one entry per dispatched
//             instruction, marks entries done from writeback and retires them
//             in program order, at most one registered commit per cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module reorder_buffer #(
  parameter int ROB_DEPTH = 8
) (
  input  wire logic           clk,
  input  wire logic           reset,
  reorder_buffer_if.slave     rob_bus
);
  localparam int ROB    = $clog2(ROB_DEPTH);
  localparam int REG_W  = 7;
  localparam int ADDR_W = 5;

  localparam logic [1:0]   TYPE_ROB   = 2'd1;
  localparam logic         ENABLE_N   = 1'b0;
  localparam logic         DISABLE_N  = 1'b1;
  localparam logic [ROB:0] FULL_COUNT = (ROB+1)'(ROB_DEPTH);

  // Per-entry state
  logic             valid_q [ROB_DEPTH];
  logic             done_q  [ROB_DEPTH];
  logic             exp_q   [ROB_DEPTH];
  logic [REG_W-1:0] rd_q    [ROB_DEPTH];

  // Pointers and occupancy; full vs empty is decided by count alone
  logic [ROB-1:0]   head_q, head_d;
  logic [ROB-1:0]   tail_q, tail_d;
  logic [ROB:0]     count_q, count_d;

  // Registered commit port
  logic             commit_e_q, commit_e_d;
  logic [REG_W-1:0] commit_rd_q, commit_rd_d;
  logic [ROB-1:0]   commit_id_q, commit_id_d;
  logic             commit_exp_q, commit_exp_d;

  logic             clear;
  logic             busy;
  logic             alloc_en;
  logic             commit_en;
  logic             wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [ROB-1:0]   wb_id;

  // Decode the cycle's actions and compute next pointer / commit values
  always_comb begin
    clear     = reset || (rob_bus.flush_ == ENABLE_N);
    busy      = (count_q == FULL_COUNT);
    alloc_en  = (rob_bus.dec_e_ == ENABLE_N) && !busy;
    commit_en = valid_q[head_q] && done_q[head_q];
    wb_addr   = rob_bus.wb_rd[ADDR_W-1:0];
    wb_id     = wb_addr[ROB-1:0];
    wb_en     = (rob_bus.wb_e_ == ENABLE_N)
             && (rob_bus.wb_rd[REG_W-1:ADDR_W] == TYPE_ROB)
             && (32'(wb_addr) < ROB_DEPTH)
             && valid_q[wb_id];

    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    commit_e_d   = DISABLE_N;
    commit_rd_d  = commit_rd_q;
    commit_id_d  = commit_id_q;
    commit_exp_d = commit_exp_q;

    if (alloc_en) begin
      tail_d = tail_q + ROB'(1);
    end

    if (commit_en) begin
      head_d       = head_q + ROB'(1);
      commit_e_d   = ENABLE_N;
      commit_rd_d  = rd_q[head_q];
      commit_id_d  = head_q;
      commit_exp_d = exp_q[head_q];
    end

    case ({alloc_en, commit_en})
      2'b10:   count_d = count_q + (ROB+1)'(1);
      2'b01:   count_d = count_q - (ROB+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer, occupancy and commit-port registers
  always_ff @(posedge clk) begin
    if (clear) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      commit_e_q   <= DISABLE_N;
      commit_rd_q  <= '0;
      commit_id_q  <= '0;
      commit_exp_q <= 1'b0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      commit_e_q   <= commit_e_d;
      commit_rd_q  <= commit_rd_d;
      commit_id_q  <= commit_id_d;
      commit_exp_q <= commit_exp_d;
    end
  end

  // Entry status bits: writeback marks done, allocation opens, commit retires
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        done_q[i]  <= 1'b0;
        exp_q[i]   <= 1'b0;
      end
    end else begin
      if (wb_en) begin
        done_q[wb_id] <= 1'b1;
        exp_q[wb_id]  <= rob_bus.wb_exp;
      end
      // An allocating entry was invalid at cycle start, so wb cannot hit it
      if (alloc_en) begin
        valid_q[tail_q] <= 1'b1;
        done_q[tail_q]  <= 1'b0;
        exp_q[tail_q]   <= 1'b0;
      end
      if (commit_en) begin
        valid_q[head_q] <= 1'b0;
      end
    end
  end

  // Destination register payload; only meaningful while the entry is valid
  always_ff @(posedge clk) begin
    if (!clear && alloc_en) begin
      rd_q[tail_q] <= rob_bus.dec_rd;
    end
  end

  assign rob_bus.dec_rob_id    = tail_q;
  assign rob_bus.busy          = busy;
  assign rob_bus.commit_e_     = commit_e_q;
  assign rob_bus.commit_rd     = commit_rd_q;
  assign rob_bus.commit_rob_id = commit_id_q;
  assign rob_bus.commit_exp    = commit_exp_q;

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reorder_buffer
//  Purpose  : Directed self-checking bench for reorder_buffer (8 entries).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reorder_buffer;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  reorder_buffer_if #(.ROB_DEPTH(DEPTH)) rob_bus ();

  reorder_buffer #(.ROB_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .rob_bus (rob_bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] gpr(input int n);
    return {2'b00, 5'(n)};
  endfunction

  function automatic logic [6:0] robt(input int n);
    return {2'b01, 5'(n)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rob_bus.flush_ = 1'b1;
    rob_bus.dec_e_ = 1'b1;
    rob_bus.dec_rd = '0;
    rob_bus.wb_e_  = 1'b1;
    rob_bus.wb_rd  = '0;
    rob_bus.wb_exp = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wb(input int id, input logic exp);
    rob_bus.wb_e_  = 1'b0;
    rob_bus.wb_rd  = robt(id);
    rob_bus.wb_exp = exp;
    tick();
    rob_bus.wb_e_  = 1'b1;
    rob_bus.wb_exp = 1'b0;
  endtask

  task automatic alloc(input int rd, input int exp_id);
    rob_bus.dec_e_ = 1'b0;
    rob_bus.dec_rd = gpr(rd);
    chk("alloc_id", 32'(rob_bus.dec_rob_id), exp_id);
    tick();
    rob_bus.dec_e_ = 1'b1;
  endtask

  initial begin
    idle_inputs();

    // 1: reset state, three allocations
    do_reset();
    chk("rst_dec_id",    32'(rob_bus.dec_rob_id), 0);
    chk("rst_busy",      32'(rob_bus.busy), 0);
    chk("rst_commit_e",  32'(rob_bus.commit_e_), 1);
    chk("rst_commit_rd", 32'(rob_bus.commit_rd), 0);
    chk("rst_commit_id", 32'(rob_bus.commit_rob_id), 0);
    chk("rst_commit_ex", 32'(rob_bus.commit_exp), 0);
    for (int i = 0; i < 3; i++) begin
      alloc(5 + i, i);
      chk("t1_commit_e", 32'(rob_bus.commit_e_), 1);
    end
    chk("t1_busy",    32'(rob_bus.busy), 0);
    chk("t1_next_id", 32'(rob_bus.dec_rob_id), 3);

    // 2: out-of-order writeback, in-order commit with two-cycle latency
    wb(1, 1'b0);
    chk("t2_no_commit_a", 32'(rob_bus.commit_e_), 1);
    wb(0, 1'b0);
    chk("t2_no_commit_b", 32'(rob_bus.commit_e_), 1);
    tick();
    chk("t2_c0_e",  32'(rob_bus.commit_e_), 0);
    chk("t2_c0_id", 32'(rob_bus.commit_rob_id), 0);
    chk("t2_c0_rd", 32'(rob_bus.commit_rd), 32'(gpr(5)));
    tick();
    chk("t2_c1_e",  32'(rob_bus.commit_e_), 0);
    chk("t2_c1_id", 32'(rob_bus.commit_rob_id), 1);
    chk("t2_c1_rd", 32'(rob_bus.commit_rd), 32'(gpr(6)));
    tick();
    chk("t2_rob2_wait", 32'(rob_bus.commit_e_), 1);
    chk("t2_id_hold",   32'(rob_bus.commit_rob_id), 1);
    tick();
    chk("t2_rob2_wait2", 32'(rob_bus.commit_e_), 1);

    // 3: fill, ignored allocation while full, free one entry
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      chk("t3_not_busy", 32'(rob_bus.busy), 0);
      alloc(i + 1, i);
    end
    chk("t3_full_busy", 32'(rob_bus.busy), 1);
    chk("t3_full_id",   32'(rob_bus.dec_rob_id), 0);
    rob_bus.dec_e_ = 1'b0;
    rob_bus.dec_rd = gpr(30);
    tick();
    chk("t3_ign_busy", 32'(rob_bus.busy), 1);
    chk("t3_ign_id",   32'(rob_bus.dec_rob_id), 0);
    wb(0, 1'b0);
    rob_bus.dec_e_ = 1'b0;
    chk("t3_wb_nocommit", 32'(rob_bus.commit_e_), 1);
    chk("t3_wb_busy",     32'(rob_bus.busy), 1);
    tick();
    chk("t3_commit_e",  32'(rob_bus.commit_e_), 0);
    chk("t3_commit_id", 32'(rob_bus.commit_rob_id), 0);
    chk("t3_commit_rd", 32'(rob_bus.commit_rd), 32'(gpr(1)));
    chk("t3_busy_clr",  32'(rob_bus.busy), 0);
    chk("t3_id_kept",   32'(rob_bus.dec_rob_id), 0);
    rob_bus.dec_e_ = 1'b1;

    // 4: ten alloc/wb/commit round trips across the wrap point
    do_reset();
    for (int k = 0; k < 10; k++) begin
      alloc(10 + k, k % DEPTH);
      chk("t4_quiet_a", 32'(rob_bus.commit_e_), 1);
      wb(k % DEPTH, 1'b0);
      chk("t4_quiet_b", 32'(rob_bus.commit_e_), 1);
      tick();
      chk("t4_commit_e",  32'(rob_bus.commit_e_), 0);
      chk("t4_commit_id", 32'(rob_bus.commit_rob_id), k % DEPTH);
      chk("t4_commit_rd", 32'(rob_bus.commit_rd), 32'(gpr(10 + k)));
    end
    chk("t4_next_id", 32'(rob_bus.dec_rob_id), 2);
    chk("t4_busy",    32'(rob_bus.busy), 0);
    tick();
    chk("t4_no_dup", 32'(rob_bus.commit_e_), 1);

    // 5: flush with pending done entries behind an undone head
    for (int i = 0; i < 4; i++) begin
      alloc(20 + i, 2 + i);
    end
    wb(3, 1'b0);
    wb(4, 1'b0);
    chk("t5_head_wait", 32'(rob_bus.commit_e_), 1);
    rob_bus.flush_ = 1'b0;
    rob_bus.wb_e_  = 1'b0;
    rob_bus.wb_rd  = robt(2);
    rob_bus.dec_e_ = 1'b0;
    tick();
    idle_inputs();
    chk("t5_dec_id",    32'(rob_bus.dec_rob_id), 0);
    chk("t5_busy",      32'(rob_bus.busy), 0);
    chk("t5_commit_e",  32'(rob_bus.commit_e_), 1);
    chk("t5_commit_id", 32'(rob_bus.commit_rob_id), 0);
    chk("t5_commit_rd", 32'(rob_bus.commit_rd), 0);
    tick();
    chk("t5_quiet_a", 32'(rob_bus.commit_e_), 1);
    wb(0, 1'b0);
    tick();
    chk("t5_quiet_b", 32'(rob_bus.commit_e_), 1);
    tick();
    chk("t5_quiet_c", 32'(rob_bus.commit_e_), 1);
    chk("t5_dec_id2", 32'(rob_bus.dec_rob_id), 0);

    // 6: exception flag carried to commit
    alloc(20, 0);
    alloc(21, 1);
    wb(0, 1'b1);
    wb(1, 1'b0);
    chk("t6_c0_e",   32'(rob_bus.commit_e_), 0);
    chk("t6_c0_id",  32'(rob_bus.commit_rob_id), 0);
    chk("t6_c0_exp", 32'(rob_bus.commit_exp), 1);
    chk("t6_c0_rd",  32'(rob_bus.commit_rd), 32'(gpr(20)));
    tick();
    chk("t6_c1_e",   32'(rob_bus.commit_e_), 0);
    chk("t6_c1_id",  32'(rob_bus.commit_rob_id), 1);
    chk("t6_c1_exp", 32'(rob_bus.commit_exp), 0);
    chk("t6_c1_rd",  32'(rob_bus.commit_rd), 32'(gpr(21)));
    tick();
    chk("t6_done", 32'(rob_bus.commit_e_), 1);

    // 7: GPR-typed writeback must not complete a ROB entry
    rob_bus.flush_ = 1'b0;
    tick();
    rob_bus.flush_ = 1'b1;
    alloc(9, 0);
    rob_bus.wb_e_ = 1'b0;
    rob_bus.wb_rd = gpr(0);
    tick();
    rob_bus.wb_e_ = 1'b1;
    tick();
    chk("t7_no_commit_a", 32'(rob_bus.commit_e_), 1);
    tick();
    chk("t7_no_commit_b", 32'(rob_bus.commit_e_), 1);
    wb(0, 1'b0);
    tick();
    chk("t7_commit_e",  32'(rob_bus.commit_e_), 0);
    chk("t7_commit_id", 32'(rob_bus.commit_rob_id), 0);
    chk("t7_commit_rd", 32'(rob_bus.commit_rd), 32'(gpr(9)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
